// File: rtl/nlfsr_search_engine.sv
// nlfsr_search_engine: streams NLFSR tap candidates, measures the seed return period and classifies each as maximal, short-cycle or stuck
module nlfsr_search_engine #(
  parameter int SIZE        = 16,
  parameter int NUM_OF_TAPS = 15,
  parameter int TAP_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         cand_valid,
  output logic                         cand_ready,
  input  logic [NUM_OF_TAPS*TAP_W-1:0] cand_taps,
  input  logic                         abort,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_found,
  output logic                         res_stuck,
  output logic [SIZE:0]                res_period,
  output logic [NUM_OF_TAPS*TAP_W-1:0] res_taps,
  output logic                         busy,
  output logic [CNT_W-1:0]             tested_cnt,
  output logic [CNT_W-1:0]             found_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, REPORT} fsm_t;
  localparam logic [SIZE-1:0] SEED = SIZE'(1);
  localparam logic [SIZE-1:0] MAXP = '1;
  fsm_t                         r_fsm, w_fsm_nxt;
  logic [SIZE-1:0]              r_state, r_cyc, w_next, w_c;
  logic [NUM_OF_TAPS-1:0]       w_v;
  logic                         w_fb, w_zero, w_seed, w_done;
  logic [NUM_OF_TAPS*TAP_W-1:0] r_taps;
  logic                         r_found, r_stuck;
  logic [SIZE:0]                r_period;
  logic [CNT_W-1:0]             r_tested, r_found_cnt;
  for (genvar k = 0; k < NUM_OF_TAPS; k++) begin : g_tap
    assign w_v[k] = |(r_state & (SEED << r_taps[k*TAP_W +: TAP_W]));
  end
  assign w_fb   = (w_v[0] & w_v[1]) ^ (^w_v[NUM_OF_TAPS-1:2]) ^ r_state[0];
  assign w_next = {w_fb, r_state[SIZE-1:1]};
  assign w_c    = r_cyc + 1'b1;
  assign w_zero = w_next == '0;
  assign w_seed = w_next == SEED;
  assign w_done = w_zero | w_seed | (w_c == MAXP);
  always_ff @(posedge clk)
    r_fsm <= res ? IDLE : w_fsm_nxt;
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_fsm_nxt = r_fsm == IDLE ? (cand_valid ? RUN : IDLE) :
                r_fsm == RUN  ? (abort ? IDLE : w_done ? REPORT : RUN) :
                (res_ready ? IDLE : REPORT);
  end
  always_ff @(posedge clk) begin
    if (res) begin
      r_taps      <= '0;
      r_state     <= SEED;
      r_cyc       <= '0;
      r_found     <= 1'b0;
      r_stuck     <= 1'b0;
      r_period    <= '0;
      r_tested    <= '0;
      r_found_cnt <= '0;
    end else begin
      if (r_fsm == IDLE && cand_valid) begin
        r_taps  <= cand_taps;
        r_state <= SEED;
        r_cyc   <= '0;
      end
      if (r_fsm == RUN && !abort) begin
        if (w_done) begin
          r_stuck  <= w_zero;
          r_found  <= w_seed && (w_c == MAXP);
          r_period <= w_seed ? {1'b0, w_c} : '0;
        end else begin
          r_state <= w_next;
          r_cyc   <= w_c;
        end
      end
      if (r_fsm == REPORT && res_ready) begin
        r_tested <= &r_tested ? r_tested : r_tested + 1'b1;
        if (r_found && !(&r_found_cnt))
          r_found_cnt <= r_found_cnt + 1'b1;
      end
    end
  end
  assign cand_ready = r_fsm == IDLE;
  assign res_valid  = r_fsm == REPORT;
  assign busy       = r_fsm != IDLE;
  assign res_found  = r_found;
  assign res_stuck  = r_stuck;
  assign res_period = r_period;
  assign res_taps   = r_taps;
  assign tested_cnt = r_tested;
  assign found_cnt  = r_found_cnt;
endmodule

// File: tb/tb_nlfsr_search_engine.sv
// tb_nlfsr_search_engine: directed scoreboard bench for nlfsr_search_engine at SIZE=4, three 4-bit tap slots, 2-bit counters
module tb_nlfsr_search_engine;
  localparam int SIZE = 4;
  localparam int NT   = 3;
  localparam int TW   = 4;
  localparam int CW   = 2;
  logic            clk = 1'b0;
  logic            res, cand_valid, abort, res_ready;
  logic [NT*TW-1:0] cand_taps;
  logic            cand_ready, res_valid, res_found, res_stuck, busy;
  logic [SIZE:0]   res_period;
  logic [NT*TW-1:0] res_taps;
  logic [CW-1:0]   tested_cnt, found_cnt;
  nlfsr_search_engine #(.SIZE(SIZE), .NUM_OF_TAPS(NT), .TAP_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .res(res), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_taps(cand_taps), .abort(abort), .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_stuck(res_stuck), .res_period(res_period),
    .res_taps(res_taps), .busy(busy), .tested_cnt(tested_cnt), .found_cnt(found_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic            found;
    logic            stuck;
    logic [SIZE:0]   period;
    logic [NT*TW-1:0] taps;
    int              lat;
  } exp_t;
  exp_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            lat = 0;
  bit            seen = 1'b1;
  int            n_res = 0;
  logic [CW-1:0] m_t = '0;
  logic [CW-1:0] m_f = '0;
  logic          l_found, l_stuck;
  logic [SIZE:0] l_period;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NT*TW-1:0] tp(input int s0, input int s1, input int s2);
    return {4'(s2), 4'(s1), 4'(s0)};
  endfunction
  function automatic exp_t model(input logic [NT*TW-1:0] t);
    exp_t       e;
    logic [3:0] st, nx, v;
    int         idx;
    e.taps = t; e.found = 1'b0; e.stuck = 1'b0; e.period = '0; e.lat = 16;
    st = 4'd1;
    for (int c = 1; c <= 15; c++) begin
      for (int k = 0; k < NT; k++) begin
        idx  = int'(t[k*TW +: TW]);
        v[k] = idx < SIZE ? st[idx] : 1'b0;
      end
      v[3] = 1'b0;
      nx = {(v[0] & v[1]) ^ v[2] ^ st[0], st[3:1]};
      if (nx == 4'd0) begin
        e.stuck = 1'b1; e.lat = c + 1;
        return e;
      end
      if (nx == 4'd1) begin
        e.period = 5'(c); e.found = (c == 15); e.lat = c + 1;
        return e;
      end
      st = nx;
    end
    return e;
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (res) begin
      q.delete();
      m_t  = '0;
      m_f  = '0;
      seen = 1'b1;
    end else begin
      lat++;
      if (cand_valid && cand_ready) begin
        q.push_back(model(cand_taps));
        lat  = 0;
        seen = 1'b0;
      end
      if (abort && busy && !res_valid) begin
        q.delete();
        seen = 1'b1;
      end
      if (res_valid && !seen) begin
        seen = 1'b1;
        if (q.size() > 0) check("latency", lat, q[0].lat);
      end
      if (res_valid && res_ready) begin
        check("queue_depth", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("res_found", res_found, e.found);
          check("res_stuck", res_stuck, e.stuck);
          check("res_period", res_period, e.period);
          check("res_taps", res_taps, e.taps);
        end
        l_found  = res_found;
        l_stuck  = res_stuck;
        l_period = res_period;
        n_res++;
        m_t = &m_t ? m_t : m_t + 1'b1;
        if (res_found && !(&m_f)) m_f = m_f + 1'b1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input logic [NT*TW-1:0] t);
    cand_taps  = t;
    cand_valid = 1'b1;
    tick();
    cand_valid = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("run_done", busy, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base;
    res = 1'b1; cand_valid = 1'b0; abort = 1'b0; res_ready = 1'b1; cand_taps = '0;
    repeat (3) tick();
    res = 1'b0;
    tick();
    check("rst_cand_ready", cand_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_found", res_found, 1'b0);
    check("rst_stuck", res_stuck, 1'b0);
    check("rst_period", res_period, 0);
    check("rst_taps", res_taps, 0);
    check("rst_tested", tested_cnt, 0);
    check("rst_found_cnt", found_cnt, 0);
    cand_taps = tp(15, 15, 1); cand_valid = 1'b1;
    tick();
    cand_valid = 1'b0;
    repeat (4) tick();
    check("midrun_busy", busy, 1'b1);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("midrst_cand_ready", cand_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_res_valid", res_valid, 1'b0);
    base = n_res;
    repeat (20) tick();
    check("midrst_no_result", n_res, base);
    check("midrst_tested", tested_cnt, 0);
    run_one(tp(15, 15, 1));
    check("x4x1_found", l_found, 1'b1);
    check("x4x1_period", l_period, 15);
    check("x4x1_tested", tested_cnt, 1);
    check("x4x1_found_cnt", found_cnt, 1);
    run_one(tp(15, 15, 3));
    check("x4x3_found", l_found, 1'b1);
    check("x4x3_period", l_period, 15);
    check("x4x3_found_cnt", found_cnt, 2);
    run_one(tp(15, 15, 2));
    check("short_found", l_found, 1'b0);
    check("short_stuck", l_stuck, 1'b0);
    check("short_period", l_period, 6);
    run_one(tp(15, 15, 15));
    check("rot_period", l_period, 4);
    run_one(tp(1, 2, 3));
    run_one(tp(15, 15, 0));
    check("stuck_flag", l_stuck, 1'b1);
    check("stuck_period", l_period, 0);
    check("cnt_tested", tested_cnt, m_t);
    check("cnt_found", found_cnt, m_f);
    res_ready = 1'b0;
    cand_taps = tp(15, 15, 1); cand_valid = 1'b1;
    tick();
    for (int i = 0; i < 40 && !res_valid; i++) tick();
    check("hold_reached", res_valid, 1'b1);
    abort = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", res_valid, 1'b1);
      check("hold_found", res_found, 1'b1);
      check("hold_stuck", res_stuck, 1'b0);
      check("hold_period", res_period, 15);
      check("hold_taps", res_taps, tp(15, 15, 1));
      check("hold_cand_ready", cand_ready, 1'b0);
    end
    abort = 1'b0; cand_valid = 1'b0; res_ready = 1'b1;
    tick();
    check("hold_release_valid", res_valid, 1'b0);
    check("hold_release_ready", cand_ready, 1'b1);
    cand_taps = tp(15, 15, 1); cand_valid = 1'b1;
    tick();
    cand_valid = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_cand_ready", cand_ready, 1'b1);
    check("abort_res_valid", res_valid, 1'b0);
    check("abort_tested", tested_cnt, m_t);
    check("abort_found", found_cnt, m_f);
    res = 1'b1;
    tick();
    res = 1'b0;
    base = n_res;
    cand_taps = tp(15, 15, 1); cand_valid = 1'b1;
    for (int i = 0; i < 200 && n_res < base + 5; i++) tick();
    cand_valid = 1'b0;
    tick();
    check("b2b_results", n_res - base, 5);
    check("b2b_found_sat", found_cnt, 3);
    check("b2b_tested_sat", tested_cnt, 3);
    check("b2b_found_model", found_cnt, m_f);
    check("b2b_idle", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
